dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the MA-stage load/store interface.
- Accepts one load/store request from the pipeline, holds it for a fixed latency, then returns one response pulse.
- Drives `busy` so the pipeline control can freeze earlier stages while an access is in flight.
- Replaces the single-cycle combinational DataMemory for the stall-capable pipeline.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MA stage: accepts one load/store,
// holds it for LATENCY cycles, then returns a single response pulse.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        latWrite;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [3:0]  latBe;

    logic [31:0] memArray [0:(2**ADDR_W)-1];

    logic              effWrite;
    logic [31:0]       effAddr;
    logic [31:0]       effWdata;
    logic [3:0]        effBe;
    logic              enterResp;
    logic              addrErr;
    logic [ADDR_W-1:0] wordIdx;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    // With LATENCY=1 the commit happens on the accepting edge itself, so the
    // live request is used instead of the not-yet-latched copy.
    always_comb begin
        effWrite = latWrite;
        effAddr  = latAddr;
        effWdata = latWdata;
        effBe    = latBe;
        if (state == IDLE) begin
            effWrite = req_write;
            effAddr  = req_addr;
            effWdata = req_wdata;
            effBe    = req_be;
        end
    end

    assign enterResp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1));
    assign addrErr   = (effAddr[1:0] != 2'b00) ||
                       ((effAddr >> (ADDR_W + 2)) != 32'd0);
    assign wordIdx   = effAddr[ADDR_W+1:2];

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enterResp;
            if (enterResp) begin
                resp_err   <= addrErr;
                resp_rdata <= (!effWrite && !addrErr) ? memArray[wordIdx] : '0;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (reset && (state == IDLE) && req_valid) begin
            latWrite <= req_write;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            latBe    <= req_be;
        end
    end

    // Array is never cleared; a reset on the commit edge suppresses the store.
    always_ff @(posedge Clk) begin
        if (reset && enterResp && effWrite && !addrErr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (effBe[i]) memArray[wordIdx][8*i +: 8] <= effWdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: one LATENCY=2 instance and one
// LATENCY=1 instance, each driven through the same transaction task.
module tb_dmem_responder;

    logic        Clk = 1'b0;
    logic        reset;
    logic        validA, validB;
    logic        reqWrite;
    logic [31:0] reqAddr, reqWdata;
    logic [3:0]  reqBe;

    logic        readyA, respValidA, respErrA, busyA;
    logic [31:0] rdataA;
    logic        readyB, respValidB, respErrB, busyB;
    logic [31:0] rdataB;

    logic        sel;
    logic        rdy, rv, rerr, bsy;
    logic [31:0] rdat;

    int nAsserts = 0;
    int nFail    = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       tag;
    } expT;
    expT sb[$];

    always #5 Clk = ~Clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) dutA (
        .Clk(Clk), .reset(reset), .req_valid(validA), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .req_ready(readyA), .resp_valid(respValidA), .resp_rdata(rdataA),
        .resp_err(respErrA), .busy(busyA)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) dutB (
        .Clk(Clk), .reset(reset), .req_valid(validB), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .req_ready(readyB), .resp_valid(respValidB), .resp_rdata(rdataB),
        .resp_err(respErrB), .busy(busyB)
    );

    assign rdy  = sel ? readyB     : readyA;
    assign rv   = sel ? respValidB : respValidA;
    assign rerr = sel ? respErrB   : respErrA;
    assign rdat = sel ? rdataB     : rdataA;
    assign bsy  = sel ? busyB      : busyA;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setValid(input logic v);
        if (sel) validB = v;
        else     validA = v;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic doReq(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] expData, input logic expErr);
        expT e;
        int  n;
        int  lat;
        lat = sel ? 1 : 2;
        reqWrite = wr; reqAddr = addr; reqWdata = wdata; reqBe = be;
        setValid(1'b1);
        chk({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        e.data = expData; e.err = expErr; e.tag = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1 setValid(1'b0);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!rv && n < 20);
        chk({tag, "_latency"}, n, lat);
        if (rv && sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_rdata"}, rdat, e.data);
            chk({e.tag, "_err"}, {31'd0, rerr}, {31'd0, e.err});
        end
        @(negedge Clk);
        chk({tag, "_pulse_end"}, {31'd0, rv}, 32'd0);
        chk({tag, "_hold"}, rdat, expData);
    endtask

    initial begin
        int pulses;
        sel = 1'b0; validA = 1'b0; validB = 1'b0;
        reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; reqBe = '0;
        reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1 reset = 1'b1;
        @(negedge Clk);
        chk("rst_ready", {31'd0, readyA}, 32'd1);
        chk("rst_busy", {31'd0, busyA}, 32'd0);
        chk("rst_rvalid", {31'd0, respValidA}, 32'd0);
        chk("rst_rdata", rdataA, 32'd0);
        chk("rst_err", {31'd0, respErrA}, 32'd0);

        // Write then read
        doReq("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        doReq("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Byte enables
        doReq("st20", 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        doReq("st20be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        doReq("ld20be", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);
        doReq("st20nop", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        doReq("ld20nop", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);

        // Misaligned and out-of-range
        doReq("ld13", 1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 1'b1);
        doReq("st22", 1'b1, 32'h22, 32'h99999999, 4'b1111, 32'h0, 1'b1);
        doReq("ld20mis", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);
        doReq("ld400", 1'b0, 32'h400, 32'h0, 4'b0000, 32'h0, 1'b1);
        doReq("st3FC", 1'b1, 32'h3FC, 32'h13579BDF, 4'b1111, 32'h0, 1'b0);
        doReq("ld3FC", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h13579BDF, 1'b0);

        // Held request: stores k to word 0x10 every cycle, only k=0,3,6 accepted
        pulses = 0;
        reqWrite = 1'b1; reqAddr = 32'h10; reqBe = 4'b1111;
        validA = 1'b1;
        for (int k = 0; k < 9; k++) begin
            reqWdata = 32'(k);
            chk($sformatf("hold_ready%0d", k), {31'd0, readyA}, {31'd0, (k % 3 == 0)});
            chk($sformatf("hold_busy%0d", k), {31'd0, busyA}, {31'd0, (k % 3 != 0)});
            chk($sformatf("hold_rv%0d", k), {31'd0, respValidA}, {31'd0, (k % 3 == 2)});
            if (respValidA) pulses++;
            @(negedge Clk);
        end
        validA = 1'b0;
        chk("hold_pulses", pulses, 3);
        chk("hold_idle", {31'd0, readyA}, 32'd1);
        doReq("ld10hold", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h6, 1'b0);

        // Reset on the RESP-entry edge discards the store
        doReq("st30", 1'b1, 32'h30, 32'h01020304, 4'b1111, 32'h0, 1'b0);
        reqWrite = 1'b1; reqAddr = 32'h30; reqWdata = 32'h5A5A5A5A; reqBe = 4'b1111;
        validA = 1'b1;
        @(posedge Clk);
        #1 validA = 1'b0;
        @(negedge Clk);
        chk("rstmid_busy", {31'd0, busyA}, 32'd1);
        reset = 1'b0;
        @(negedge Clk);
        chk("rstmid_rv0", {31'd0, respValidA}, 32'd0);
        @(negedge Clk);
        reset = 1'b1;
        chk("rstmid_rv1", {31'd0, respValidA}, 32'd0);
        @(negedge Clk);
        chk("rstmid_rv2", {31'd0, respValidA}, 32'd0);
        chk("rstmid_ready", {31'd0, readyA}, 32'd1);
        doReq("ld30rst", 1'b0, 32'h30, 32'h0, 4'b0000, 32'h01020304, 1'b0);
        doReq("ld10rst", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h6, 1'b0);

        // LATENCY=1 instance
        sel = 1'b1;
        chk("l1_rdy_vs_busy", {31'd0, rdy}, {31'd0, ~bsy});
        doReq("l1_st08", 1'b1, 32'h08, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        doReq("l1_ld08", 1'b0, 32'h08, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
        doReq("l1_ld07", 1'b0, 32'h07, 32'h0, 4'b0000, 32'h0, 1'b1);
        reqWrite = 1'b1; reqAddr = 32'h0C; reqBe = 4'b1111;
        validB = 1'b1;
        for (int k = 0; k < 4; k++) begin
            reqWdata = 32'(k);
            chk($sformatf("l1_hold_ready%0d", k), {31'd0, readyB}, {31'd0, (k % 2 == 0)});
            chk($sformatf("l1_hold_rv%0d", k), {31'd0, respValidB}, {31'd0, (k % 2 == 1)});
            @(negedge Clk);
        end
        validB = 1'b0;
        doReq("l1_ld0C", 1'b0, 32'h0C, 32'h0, 4'b0000, 32'h2, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
